fp_addsub_seq: RTL
==================

# fp_addsub_seq

Multi-cycle, parametrised IEEE-754-style floating-point adder/subtractor with a start/busy/done handshake. It computes `op_a + op_b`, or `op_a - op_b` when `sub` is set, with round-to-nearest-even, fixed latency and overflow/underflow/zero flags. It supports any exponent/mantissa split and is the FP add/subtract unit behind the datapath's arithmetic service request.

## Interface
- `EXP_W`, default 8: exponent width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, default 23: stored mantissa width, excluding the hidden bit.
- `clk` input 1: rising-edge clock.
- `n_rst` input 1: reset, synchronous, active-low.
- `start` input 1: request; accepted only in IDLE or DONE.
- `sub` input 1: 0 = add, 1 = subtract; sampled with `start`.
- `op_a`, `op_b` input 1+EXP_W+MAN_W: operands {sign, exp, man}; sampled with `start`.
- `result` output 1+EXP_W+MAN_W: registered result; held until the next result is written.
- `busy` output 1: high in ALIGN, ADD, NORM and ROUND.
- `done` output 1: single-cycle pulse in DONE; `result` and flags are valid.
- `overflow` output 1: result saturated to ±inf.
- `underflow` output 1: result flushed to ±0.
- `zero` output 1: result magnitude is 0.

## Operation
- FSM states: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- Transitions: IDLE→ALIGN on `start`; ALIGN→ADD→NORM→ROUND→DONE unconditionally; DONE→ALIGN if `start`, otherwise DONE→IDLE.
- Capture: on an accepted `start`, register the operands and set effective b-sign = `op_b[msb] ^ sub`.
- Operand classes:
  - exp == 0 is treated as zero (denormals flushed).
  - exp == all-ones as input produces ±inf with `overflow`=1. The sign is op_a's, or op_b's effective sign if only op_b is special.
- ALIGN:
  - Significand = {hidden 1, man}. Swap so the larger magnitude is A.
  - Shift B right by the exp difference into a MAN_W+4-bit field {sig, guard, round, sticky}. Shifted-out bits OR into sticky.
  - Difference > MAN_W+3 leaves B as sticky only.
- ADD:
  - Same effective sign: add, with a MAN_W+5-bit sum including carry.
  - Differing signs: A−B, never negative after the swap. Result sign = A's sign.
- NORM:
  - Carry set: shift right 1 (LSB ORs into sticky) and exp+1.
  - Otherwise: shift left by the leading-zero count (from `fp_lzc`) and exp−lzc, in one cycle.
- ROUND:
  - RNE: increment if guard & (round | sticky | lsb).
  - Mantissa rollover: exp+1.
- Result rules:
  - Exact cancellation → +0, `zero`=1.
  - Exp ≥ all-ones after rounding → ±inf (man 0), `overflow`=1.
  - Exp ≤ 0 → ±0, `underflow`=1, `zero`=1.
- Flags clear on every accepted `start`.

## Timing
- Reset, on a clock edge with `n_rst`=0:
  - state = IDLE.
  - `result`=0, `busy`=0, `done`=0, `overflow`=0, `underflow`=0, `zero`=0.
  - Internal registers cleared.
- Reset mid-operation aborts the operation; no `done` is issued.
- Latency: `start` accepted at edge t → `busy`=1 for cycles t+1..t+4 → `done`=1 and result valid in cycle t+5.
- `start` while `busy` is ignored; no queueing.
- `start` in DONE is accepted in the same cycle. Maximum throughput is one operation per 5 cycles.
- `sub`, `op_a` and `op_b` are don't-care except on the accepting edge.

## Structure
- Shared package `fp_pkg`:
  - State enum `fp_state_t`.
  - Default localparams `FP_EXP_W=8` and `FP_MAN_W=23`.
  - Helper functions for field extraction and bias.
- Sub-module `fp_lzc`: parametrised combinational leading-zero counter over MAN_W+4 bits, output width $clog2(MAN_W+5).
- Top-level estimate: about 250 lines.

## Test plan
- 1.0 + 1.0 (`op_a`=`op_b`=0x3F800000, `sub`=0) → `result`=0x40000000, `done` exactly 5 cycles after `start`, all flags 0.
- 0x3FC00000 − 0x3FA00000 (`sub`=1) → 0x3E800000; exercises the 2-position left normalisation.
- 3.0 − 3.0 (0x40400000, `sub`=1) → 0x00000000 with `zero`=1. Also 0x40400000 + 0xC0400000 → +0.
- 0x3F800000 + 0x33800000 (exact tie) → 0x3F800000 (RNE to even). 0x3F800001 + 0x33800000 → 0x3F800002.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with `overflow`=1. Add with an input exp=0xFF → ±inf with `overflow`=1.
- Handshake and reset:
  - `start` pulsed while `busy` → ignored, first result unchanged.
  - Back-to-back `start` in DONE → second `done` 5 cycles later.
  - `n_rst`=0 in NORM → all outputs 0 on the next edge, no `done`.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the floating-point add/subtract unit.
//   fp_state_t     - sequencer states (IDLE, ALIGN, ADD, NORM, ROUND, DONE)
//   FP_EXP_W/MAN_W - default single-precision field split
//   fp_bias()      - exponent bias for a given exponent width
//   fp_sign_pos()  - bit position of the sign in {sign, exp, man}
//   fp_exp_lsb()   - bit position of the exponent LSB in {sign, exp, man}
package fp_pkg;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ALIGN = 3'd1,
      ST_ADD   = 3'd2,
      ST_NORM  = 3'd3,
      ST_ROUND = 3'd4,
      ST_DONE  = 3'd5
   } fp_state_t;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic int fp_sign_pos(input int exp_w, input int man_w);
      return exp_w + man_w;
   endfunction

   function automatic int fp_exp_lsb(input int man_w);
      return man_w;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter.
//   din   [WIDTH-1:0] - value to scan from the MSB
//   count [CNT_W-1:0] - number of leading zeros; WIDTH when din is all zero
module fp_lzc #(
   parameter int WIDTH = 27,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] din,
   output logic [CNT_W-1:0] count
);

   // Scan LSB to MSB so the highest set bit is the last one to assign.
   always_comb begin
      count = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (din[i]) count = CNT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle floating-point adder/subtractor, round to
// nearest even, denormals flushed to zero, fixed 5-cycle latency.
//   clk, n_rst          - clock, synchronous active-low reset
//   start, sub          - request and add(0)/subtract(1) select
//   op_a, op_b          - operands {sign, exp, man}
//   result              - registered result, held until the next one
//   busy, done          - busy in ALIGN..ROUND, done pulses in DONE
//   overflow, underflow - saturated to +-inf / flushed to +-0
//   zero                - result magnitude is zero
//   dbg_state           - current sequencer state
//
// Handshake: start is accepted only in IDLE or DONE; sub/op_a/op_b are
// sampled on that same edge. An accepted start at edge t gives busy=1 in
// cycles t+1..t+4 and a single done pulse with valid result/flags in t+5.
// start while busy is dropped, nothing is queued.
module fp_addsub_seq
   import fp_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     start,
   input  logic                     sub,
   input  logic [EXP_W+MAN_W:0]     op_a,
   input  logic [EXP_W+MAN_W:0]     op_b,
   output logic [EXP_W+MAN_W:0]     result,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow,
   output logic                     underflow,
   output logic                     zero,
   output fp_state_t                dbg_state
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int FW   = MAN_W + 4;             // {sig, guard, round, sticky}
   localparam int LZ_W = $clog2(MAN_W + 5);
   localparam int EW   = EXP_W + LZ_W + 2;      // signed working exponent
   localparam logic [EXP_W-1:0]        EXP_ONES = '1;
   localparam logic signed [EW-1:0]    EXP_MAX  = EW'((1 << EXP_W) - 1);

   fp_state_t state_q, state_d;
   logic [W-1:0]           result_q, result_d;
   logic                   busy_q, busy_d, done_q, done_d;
   logic                   ovf_q, ovf_d, unf_q, unf_d, zero_q, zero_d;
   logic                   sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic [EXP_W-1:0]       exp_a_q, exp_a_d, exp_b_q, exp_b_d;
   logic [MAN_W-1:0]       man_a_q, man_a_d, man_b_q, man_b_d;
   logic                   special_q, special_d, spec_sign_q, spec_sign_d;
   logic                   sign_q, sign_d, eff_sub_q, eff_sub_d;
   logic signed [EW-1:0]   exp_q, exp_d;
   logic [FW-1:0]          sig_a_q, sig_a_d, sig_b_q, sig_b_d;
   logic [FW:0]            sum_q, sum_d;
   logic [FW-1:0]          norm_q, norm_d;

   // alignment / rounding intermediates
   logic                   a_zero, b_zero, a_spec, b_spec, swap;
   logic [EXP_W+MAN_W-1:0] key_a, key_b;
   logic [EXP_W-1:0]       big_exp, small_exp;
   logic [FW-1:0]          big_sig, small_sig, shifted;
   logic [31:0]            diff;
   logic                   lost;
   logic [LZ_W-1:0]        lz_cnt;
   logic                   rnd_inc;
   logic [MAN_W+1:0]       rnd_sig;
   logic signed [EW-1:0]   rnd_exp;
   logic [MAN_W-1:0]       rnd_man;

   fp_lzc #(.WIDTH(FW), .CNT_W(LZ_W)) u_lzc (
      .din   (sum_q[FW-1:0]),
      .count (lz_cnt)
   );

   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      zero_d      = zero_q;
      sign_a_d    = sign_a_q;
      sign_b_d    = sign_b_q;
      exp_a_d     = exp_a_q;
      exp_b_d     = exp_b_q;
      man_a_d     = man_a_q;
      man_b_d     = man_b_q;
      special_d   = special_q;
      spec_sign_d = spec_sign_q;
      sign_d      = sign_q;
      eff_sub_d   = eff_sub_q;
      exp_d       = exp_q;
      sig_a_d     = sig_a_q;
      sig_b_d     = sig_b_q;
      sum_d       = sum_q;
      norm_d      = norm_q;

      // Exponent 0 means zero; a zeroed key makes it the smaller operand.
      a_zero    = (exp_a_q == '0);
      b_zero    = (exp_b_q == '0);
      a_spec    = (exp_a_q == EXP_ONES);
      b_spec    = (exp_b_q == EXP_ONES);
      key_a     = a_zero ? '0 : {exp_a_q, man_a_q};
      key_b     = b_zero ? '0 : {exp_b_q, man_b_q};
      swap      = (key_b > key_a);
      big_exp   = swap ? exp_b_q : exp_a_q;
      small_exp = swap ? exp_a_q : exp_b_q;
      big_sig   = (swap ? b_zero : a_zero) ? '0 :
                  {1'b1, (swap ? man_b_q : man_a_q), 3'b000};
      small_sig = (swap ? a_zero : b_zero) ? '0 :
                  {1'b1, (swap ? man_a_q : man_b_q), 3'b000};
      diff      = 32'(big_exp) - 32'(small_exp);
      if (diff >= 32'(FW)) begin
         shifted = '0;
         lost    = |small_sig;
      end else begin
         shifted = small_sig >> diff;
         lost    = |(small_sig << (32'(FW) - diff));
      end

      // Round-to-nearest-even on the normalised {1, man, g, r, s} field.
      rnd_inc = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
      rnd_sig = {1'b0, norm_q[FW-1:3]} + (MAN_W+2)'(rnd_inc);
      rnd_exp = rnd_sig[MAN_W+1] ? exp_q + EW'(1) : exp_q;
      rnd_man = rnd_sig[MAN_W+1] ? rnd_sig[MAN_W:1] : rnd_sig[MAN_W-1:0];

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start) begin
               state_d  = ST_ALIGN;
               sign_a_d = op_a[W-1];
               exp_a_d  = op_a[W-2:MAN_W];
               man_a_d  = op_a[MAN_W-1:0];
               sign_b_d = op_b[W-1] ^ sub;
               exp_b_d  = op_b[W-2:MAN_W];
               man_b_d  = op_b[MAN_W-1:0];
               ovf_d    = 1'b0;
               unf_d    = 1'b0;
               zero_d   = 1'b0;
            end
         end
         ST_ALIGN: begin
            state_d     = ST_ADD;
            special_d   = a_spec | b_spec;
            spec_sign_d = a_spec ? sign_a_q : sign_b_q;
            sign_d      = swap ? sign_b_q : sign_a_q;
            eff_sub_d   = sign_a_q ^ sign_b_q;
            exp_d       = $signed({{(EW-EXP_W){1'b0}}, big_exp});
            sig_a_d     = big_sig;
            sig_b_d     = {shifted[FW-1:1], shifted[0] | lost};
         end
         ST_ADD: begin
            state_d = ST_NORM;
            // After the swap A >= B, so the difference is never negative.
            sum_d = eff_sub_q ? ({1'b0, sig_a_q} - {1'b0, sig_b_q})
                              : ({1'b0, sig_a_q} + {1'b0, sig_b_q});
         end
         ST_NORM: begin
            state_d = ST_ROUND;
            if (sum_q[FW]) begin
               norm_d = {sum_q[FW:2], sum_q[1] | sum_q[0]};
               exp_d  = exp_q + EW'(1);
            end else begin
               norm_d = sum_q[FW-1:0] << lz_cnt;
               exp_d  = exp_q - $signed({{(EW-LZ_W){1'b0}}, lz_cnt});
            end
         end
         ST_ROUND: begin
            state_d = ST_DONE;
            if (special_q) begin
               result_d = {spec_sign_q, EXP_ONES, {MAN_W{1'b0}}};
               ovf_d    = 1'b1;
            end else if (norm_q == '0) begin
               result_d = '0;
               zero_d   = 1'b1;
            end else if (rnd_exp >= EXP_MAX) begin
               result_d = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
               ovf_d    = 1'b1;
            end else if (rnd_exp[EW-1] || rnd_exp == '0) begin
               result_d = {sign_q, {(W-1){1'b0}}};
               unf_d    = 1'b1;
               zero_d   = 1'b1;
            end else begin
               result_d = {sign_q, rnd_exp[EXP_W-1:0], rnd_man};
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_ALIGN) || (state_d == ST_ADD) ||
               (state_d == ST_NORM)  || (state_d == ST_ROUND);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q     <= ST_IDLE;
         result_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         zero_q      <= 1'b0;
         sign_a_q    <= 1'b0;
         sign_b_q    <= 1'b0;
         exp_a_q     <= '0;
         exp_b_q     <= '0;
         man_a_q     <= '0;
         man_b_q     <= '0;
         special_q   <= 1'b0;
         spec_sign_q <= 1'b0;
         sign_q      <= 1'b0;
         eff_sub_q   <= 1'b0;
         exp_q       <= '0;
         sig_a_q     <= '0;
         sig_b_q     <= '0;
         sum_q       <= '0;
         norm_q      <= '0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         zero_q      <= zero_d;
         sign_a_q    <= sign_a_d;
         sign_b_q    <= sign_b_d;
         exp_a_q     <= exp_a_d;
         exp_b_q     <= exp_b_d;
         man_a_q     <= man_a_d;
         man_b_q     <= man_b_d;
         special_q   <= special_d;
         spec_sign_q <= spec_sign_d;
         sign_q      <= sign_d;
         eff_sub_q   <= eff_sub_d;
         exp_q       <= exp_d;
         sig_a_q     <= sig_a_d;
         sig_b_q     <= sig_b_d;
         sum_q       <= sum_d;
         norm_q      <= norm_d;
      end
   end

   assign result    = result_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   assign zero      = zero_q;
   assign dbg_state = state_q;

endmodule
